// File: rtl/moldudp64_pkg.sv
// Shared types and constants for the MoldUDP64 payload path.
// Beat geometry, counter widths and sequencer states.
package moldudp64_pkg;

  localparam int MSG_LEN_W  = 16;
  localparam int BEAT_BYTES = 8;
  localparam int MSG_CNT_W  = 16;

  typedef enum logic {
    IDLE,
    RUN
  } beat_seq_fsm_e;

endpackage

// File: rtl/moldudp64_beat_seq_len_to_mask.sv
// Length to thermometer byte mask.
// Bit i is set when i < len; saturates to all ones at LEN_MAX.
module len_to_mask #(
  parameter int LEN_W   = 4,
  parameter int LEN_MAX = 8
) (
  input  logic [LEN_W-1:0]   len,
  output logic [LEN_MAX-1:0] mask
);

  // one bit per byte lane, set below the length
  always_comb begin
    mask = '0;
    for (int i = 0; i < LEN_MAX; i++) begin
      if (i < int'(len)) mask[i] = 1'b1;
    end
  end

endmodule

// File: rtl/moldudp64_beat_seq.sv
// MoldUDP64 beat sequencer: length command in, one
// 8-byte beat descriptor per cycle out, plus message count.
module moldudp64_beat_seq
  import moldudp64_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int LEN_W  = 16,
  parameter int BEAT_W = LEN_W - 3
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [LEN_W-1:0]     cmd_len_i,
  input  logic                 flush_i,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [KEEP_W-1:0]    beat_mask_o,
  output logic                 beat_last_o,
  output logic [BEAT_W-1:0]    beat_idx_o,
  output logic                 busy_o,
  output logic [MSG_CNT_W-1:0] msg_cnt_o
);

  localparam logic [LEN_W-1:0] STEP = LEN_W'(DATA_W / 8);
  localparam logic [LEN_W-1:0] BB   = LEN_W'(BEAT_BYTES);

  beat_seq_fsm_e        state, state_n;
  logic [LEN_W-1:0]     rem, rem_n;
  logic [BEAT_W-1:0]    idx_n;
  logic [MSG_CNT_W-1:0] cnt_n;
  logic [KEEP_W-1:0]    part_mask;
  logic                 rem_lt, rem_le;
  logic                 hs, done, acc, zlen;

  assign rem_lt = rem < BB;
  assign rem_le = rem <= BB;

  len_to_mask #(
    .LEN_W  (4),
    .LEN_MAX(KEEP_W)
  ) u_mask (
    .len (rem[3:0]),
    .mask(part_mask)
  );

  assign beat_valid_o = state == RUN;
  assign busy_o       = state == RUN;
  assign beat_last_o  = beat_valid_o & rem_le;

  // tail beat takes the thermometer, others are full
  always_comb begin
    beat_mask_o = '0;
    if (beat_valid_o) beat_mask_o = rem_lt ? part_mask : '1;
  end

  assign hs   = beat_valid_o & beat_ready_i;
  assign done = hs & beat_last_o;
  assign zlen = cmd_len_i == '0;

  assign cmd_ready_o = nreset & ~flush_i
                     & ((state == IDLE) | done);
  assign acc = cmd_valid_i & cmd_ready_o;

  // next state and datapath: flush, then accept, then beat
  always_comb begin
    state_n = state;
    rem_n   = rem;
    idx_n   = beat_idx_o;
    cnt_n   = msg_cnt_o
            + MSG_CNT_W'(done)
            + MSG_CNT_W'(acc & zlen);
    if (flush_i) begin
      state_n = IDLE;
      rem_n   = '0;
      idx_n   = '0;
    end else if (acc) begin
      idx_n = '0;
      if (zlen) begin
        state_n = IDLE;
        rem_n   = '0;
      end else begin
        state_n = RUN;
        rem_n   = cmd_len_i;
      end
    end else if (hs) begin
      if (beat_last_o) begin
        state_n = IDLE;
        rem_n   = '0;
        idx_n   = '0;
      end else begin
        rem_n = rem - STEP;
        idx_n = beat_idx_o + BEAT_W'(1);
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!nreset) state <= IDLE;
    else         state <= state_n;
  end

  // remaining bytes, beat index and message counter
  always_ff @(posedge clk) begin
    if (!nreset) begin
      rem        <= '0;
      beat_idx_o <= '0;
      msg_cnt_o  <= '0;
    end else begin
      rem        <= rem_n;
      beat_idx_o <= idx_n;
      msg_cnt_o  <= cnt_n;
    end
  end

  a_mask_thermo : assert property (@(posedge clk)
    $onehot({1'b0, beat_mask_o} + (KEEP_W+1)'(1)));

  a_last_valid : assert property (@(posedge clk)
    beat_last_o |-> beat_valid_o);

  a_stall_hold : assert property (@(posedge clk)
    disable iff (!nreset)
    (beat_valid_o && !beat_ready_i && !flush_i)
    |=> ($stable(beat_mask_o) && $stable(beat_last_o)
         && $stable(beat_idx_o)));

endmodule

// File: tb/tb_moldudp64_beat_seq.sv
// Bench for moldudp64_beat_seq: directed table,
// hand sequences and a random run against a beat model.
module tb_moldudp64_beat_seq;

  logic        clk;
  logic        nreset;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [15:0] cmd_len_i;
  logic        flush_i;
  logic        beat_valid_o;
  logic        beat_ready_i;
  logic [7:0]  beat_mask_o;
  logic        beat_last_o;
  logic [12:0] beat_idx_o;
  logic        busy_o;
  logic [15:0] msg_cnt_o;

  int total = 0;
  int bad   = 0;

  moldudp64_beat_seq dut (
    .clk         (clk),
    .nreset      (nreset),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_len_i   (cmd_len_i),
    .flush_i     (flush_i),
    .beat_valid_o(beat_valid_o),
    .beat_ready_i(beat_ready_i),
    .beat_mask_o (beat_mask_o),
    .beat_last_o (beat_last_o),
    .beat_idx_o  (beat_idx_o),
    .busy_o      (busy_o),
    .msg_cnt_o   (msg_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [15:0] len;
    logic        br;
    logic        fl;
    logic        ev;
    logic [7:0]  em;
    logic        el;
    logic [12:0] ei;
    logic        er;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    cmd_valid_i  = 1'b0;
    cmd_len_i    = '0;
    flush_i      = 1'b0;
    beat_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    idle_in();
    repeat (3) @(negedge clk);
    #1 chk("rst_ready", cmd_ready_o, 0);
    nreset = 1'b1;
    #1 chk("post_rst_ready", cmd_ready_o, 1);
  endtask

  // model of the message in flight
  bit inflight;
  int mlen, k, mcnt;
  logic [7:0] e_mask;
  logic       e_last, e_rdy;

  function automatic logic [7:0] thermo(input int n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return (n >= 8) ? 8'hFF : t[7:0];
  endfunction

  task automatic model_eval();
    int n;
    n      = mlen - 8 * k;
    e_mask = inflight ? thermo(n) : 8'h00;
    e_last = inflight && (n <= 8);
    e_rdy  = !flush_i && (!inflight || (beat_ready_i && e_last));
  endtask

  task automatic model_step();
    bit hs, dn, acc;
    hs  = inflight && beat_ready_i;
    dn  = hs && e_last;
    acc = cmd_valid_i && e_rdy;
    mcnt = (mcnt + int'(dn) + int'(acc && cmd_len_i == 0)) % 65536;
    if (flush_i) inflight = 0;
    else if (acc && cmd_len_i != 0) begin
      inflight = 1;
      mlen = cmd_len_i;
      k = 0;
    end else if (acc || dn) inflight = 0;
    else if (hs) k++;
  endtask

  initial begin
    nreset = 1'b0;
    idle_in();

    // L=20, L=8+L=1 back to back, L=0, L=17 stall, flush
    tbl[0]  = '{1, 20, 1, 0, 0, 8'h00, 0, 0, 1, 0};
    tbl[1]  = '{0, 0,  1, 0, 1, 8'hFF, 0, 0, 0, 0};
    tbl[2]  = '{0, 0,  1, 0, 1, 8'hFF, 0, 1, 0, 0};
    tbl[3]  = '{0, 0,  1, 0, 1, 8'h0F, 1, 2, 1, 0};
    tbl[4]  = '{1, 8,  1, 0, 0, 8'h00, 0, 0, 1, 1};
    tbl[5]  = '{1, 1,  1, 0, 1, 8'hFF, 1, 0, 1, 1};
    tbl[6]  = '{0, 0,  1, 0, 1, 8'h01, 1, 0, 1, 2};
    tbl[7]  = '{1, 0,  1, 0, 0, 8'h00, 0, 0, 1, 3};
    tbl[8]  = '{1, 17, 1, 0, 0, 8'h00, 0, 0, 1, 4};
    tbl[9]  = '{0, 0,  1, 0, 1, 8'hFF, 0, 0, 0, 4};
    tbl[10] = '{0, 0,  0, 0, 1, 8'hFF, 0, 1, 0, 4};
    tbl[11] = '{0, 0,  0, 0, 1, 8'hFF, 0, 1, 0, 4};
    tbl[12] = '{0, 0,  1, 0, 1, 8'hFF, 0, 1, 0, 4};
    tbl[13] = '{0, 0,  0, 0, 1, 8'h01, 1, 2, 0, 4};
    tbl[14] = '{0, 0,  1, 0, 1, 8'h01, 1, 2, 1, 4};
    tbl[15] = '{1, 40, 1, 0, 0, 8'h00, 0, 0, 1, 5};
    tbl[16] = '{0, 0,  1, 0, 1, 8'hFF, 0, 0, 0, 5};
    tbl[17] = '{1, 5,  0, 1, 1, 8'hFF, 0, 1, 0, 5};
    tbl[18] = '{0, 0,  1, 0, 0, 8'h00, 0, 0, 1, 5};
    tbl[19] = '{0, 0,  1, 0, 0, 8'h00, 0, 0, 1, 5};

    @(negedge clk);
    #1;
    chk("rst_valid", beat_valid_o, 0);
    chk("rst_mask", beat_mask_o, 0);
    chk("rst_last", beat_last_o, 0);
    chk("rst_idx", beat_idx_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", msg_cnt_o, 0);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmd_valid_i  = tbl[i].cv;
      cmd_len_i    = tbl[i].len;
      beat_ready_i = tbl[i].br;
      flush_i      = tbl[i].fl;
      #1;
      chk($sformatf("t%0d_valid", i), beat_valid_o, tbl[i].ev);
      chk($sformatf("t%0d_busy", i), busy_o, tbl[i].ev);
      chk($sformatf("t%0d_mask", i), beat_mask_o, tbl[i].em);
      chk($sformatf("t%0d_last", i), beat_last_o, tbl[i].el);
      if (tbl[i].ev)
        chk($sformatf("t%0d_idx", i), beat_idx_o, tbl[i].ei);
      chk($sformatf("t%0d_ready", i), cmd_ready_o, tbl[i].er);
      chk($sformatf("t%0d_cnt", i), msg_cnt_o, tbl[i].ec);
    end

    // counter wrap: 65535 empty messages, then L=3
    do_reset();
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_len_i   = 16'd0;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    #1;
    chk("wrap_pre_cnt", msg_cnt_o, 16'hFFFF);
    chk("wrap_pre_busy", busy_o, 0);
    cmd_valid_i = 1'b1;
    cmd_len_i   = 16'd3;
    #1 chk("wrap_ready", cmd_ready_o, 1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    #1;
    chk("wrap_valid", beat_valid_o, 1);
    chk("wrap_mask", beat_mask_o, 8'h07);
    chk("wrap_last", beat_last_o, 1);
    @(negedge clk);
    #1;
    chk("wrap_cnt", msg_cnt_o, 16'h0000);
    chk("wrap_idle", beat_valid_o, 0);

    // reset in the middle of a stalled message
    do_reset();
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_len_i   = 16'd0;
    @(negedge clk);
    cmd_len_i = 16'd40;
    @(negedge clk);
    cmd_valid_i  = 1'b0;
    beat_ready_i = 1'b0;
    #1;
    chk("mid_valid", beat_valid_o, 1);
    chk("mid_cnt", msg_cnt_o, 1);
    nreset = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", beat_valid_o, 0);
    chk("mid_rst_mask", beat_mask_o, 0);
    chk("mid_rst_last", beat_last_o, 0);
    chk("mid_rst_idx", beat_idx_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_cnt", msg_cnt_o, 0);
    chk("mid_rst_ready", cmd_ready_o, 0);
    nreset = 1'b1;
    beat_ready_i = 1'b1;
    #1 chk("mid_rel_ready", cmd_ready_o, 1);

    // random traffic against the model
    do_reset();
    inflight = 0;
    mlen = 0;
    k = 0;
    mcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cmd_valid_i  = 1'($urandom_range(0, 1));
      cmd_len_i    = ($urandom_range(0, 3) == 0) ? 16'd0
                   : 16'($urandom_range(1, 48));
      beat_ready_i = $urandom_range(0, 3) != 0;
      flush_i      = $urandom_range(0, 24) == 0;
      #1;
      model_eval();
      chk("r_valid", beat_valid_o, inflight);
      chk("r_busy", busy_o, inflight);
      chk("r_mask", beat_mask_o, e_mask);
      chk("r_last", beat_last_o, e_last);
      if (inflight) chk("r_idx", beat_idx_o, k);
      chk("r_ready", cmd_ready_o, e_rdy);
      chk("r_cnt", msg_cnt_o, mcnt);
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
